// File: rtl/maze_geom_pkg.sv
// Shared maze/sprite geometry, direction encoding and probe types.
// Also used by the movement and rendering blocks.
package maze_geom_pkg;

  localparam int unsigned SPRITE    = 30;
  localparam int unsigned STEP      = 2;
  localparam int unsigned MAZE_X0   = 150;
  localparam int unsigned MAZE_Y0   = 34;
  localparam int unsigned MAZE_W    = 480;
  localparam int unsigned MAZE_H    = 480;
  localparam int unsigned TUNNEL_Y0 = 250;
  localparam int unsigned TUNNEL_Y1 = 290;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned ARITH_W = 11;
  localparam int unsigned NPROBE  = 12;

  typedef enum logic [1:0] {
    DIR_R = 2'd0,
    DIR_L = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  typedef logic [3:0] probe_idx_t;

  // Tag that follows a probe through the one-cycle ROM latency
  typedef struct packed {
    logic valid;
    dir_e dir;
    logic oob;
    logic tun;
  } probe_tag_t;

endpackage

// File: rtl/maze_probe_gen.sv
// Combinational probe-point generator: (px, py, probe index) -> maze address,
// out-of-bounds flag, tunnel-band flag and direction.
module maze_probe_gen
  import maze_geom_pkg::*;
(
  input  logic [POS_W-1:0]  px,
  input  logic [POS_W-1:0]  py,
  input  probe_idx_t        idx,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              oob,
  output logic              tun,
  output dir_e              dir
);

  localparam logic signed [ARITH_W-1:0] X0_S  = ARITH_W'(MAZE_X0);
  localparam logic signed [ARITH_W-1:0] Y0_S  = ARITH_W'(MAZE_Y0);
  localparam logic signed [ARITH_W-1:0] W_S   = ARITH_W'(MAZE_W);
  localparam logic signed [ARITH_W-1:0] H_S   = ARITH_W'(MAZE_H);
  localparam logic signed [ARITH_W-1:0] TY0_S = ARITH_W'(TUNNEL_Y0);
  localparam logic signed [ARITH_W-1:0] TY1_S = ARITH_W'(TUNNEL_Y1);

  logic signed [ARITH_W-1:0] px_s, py_s, off, x, y, r, c;
  logic [1:0] sel;
  logic       row_oob, col_oob;

  always_comb begin
    px_s = $signed(ARITH_W'(px));
    py_s = $signed(ARITH_W'(py));
    dir  = DIR_R;
    sel  = 2'(idx);
    if (idx < 4'd3) begin
      dir = DIR_R;
      sel = 2'(idx);
    end else if (idx < 4'd6) begin
      dir = DIR_L;
      sel = 2'(idx - 4'd3);
    end else if (idx < 4'd9) begin
      dir = DIR_U;
      sel = 2'(idx - 4'd6);
    end else begin
      dir = DIR_D;
      sel = 2'(idx - 4'd9);
    end

    // Offsets along the leading edge: first, middle and last pixel
    case (sel)
      2'd0:    off = '0;
      2'd1:    off = ARITH_W'(SPRITE / 2 - 1);
      default: off = ARITH_W'(SPRITE - 1);
    endcase

    case (dir)
      DIR_R: begin
        x = px_s + ARITH_W'(SPRITE + STEP);
        y = py_s + off;
      end
      DIR_L: begin
        x = px_s - ARITH_W'(STEP - 1);
        y = py_s + off;
      end
      DIR_U: begin
        x = px_s + ARITH_W'(1) + off;
        y = py_s - ARITH_W'(STEP);
      end
      default: begin
        x = px_s + ARITH_W'(1) + off;
        y = py_s + ARITH_W'(SPRITE - 1 + STEP);
      end
    endcase

    r       = y - Y0_S;
    c       = x - X0_S;
    row_oob = (r < 0) || (r >= H_S);
    col_oob = (c < 0) || (c >= W_S);
    oob     = row_oob || col_oob;
    tun     = ((dir == DIR_L) || (dir == DIR_R)) && col_oob && !row_oob &&
              (y >= TY0_S) && (y <= TY1_S);
    row     = ADDR_W'(r);
    col     = ADDR_W'(c);
  end

endmodule

// File: rtl/maze_legal_checker.sv
// Sweeps the sprite's leading edges against the wall ROM every 15 cycles and
// publishes registered per-direction legality. Option: MAZE_TUNNEL_WRAP_EN.
module maze_legal_checker
  import maze_geom_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [POS_W-1:0]  xpos,
  input  logic [POS_W-1:0]  ypos,
  output logic              wall_re,
  output logic [ADDR_W-1:0] wall_row,
  output logic [ADDR_W-1:0] wall_col,
  input  logic              wall_bit,
  output logic              leg_l,
  output logic              leg_r,
  output logic              leg_u,
  output logic              leg_d,
  output logic              sweep_done
);

  typedef enum logic [1:0] {SNAP, PROBE, DRAIN, COMMIT} state_e;

  state_e            state, state_nxt;
  probe_idx_t        idx, idx_nxt;
  logic              issue_c;
  logic [POS_W-1:0]  px, py, src_x, src_y;
  logic [ADDR_W-1:0] g_row, g_col;
  logic              g_oob, g_tun, tun_ok_c, blocked_c;
  dir_e              g_dir;
  probe_tag_t        tag1, tag2;
  logic [3:0]        acc, acc_cap_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SNAP;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Probe index is prepared one cycle ahead so ROM strobes can be registered
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    issue_c   = 1'b0;
    case (state)
      SNAP: begin
        state_nxt = PROBE;
        idx_nxt   = '0;
        issue_c   = 1'b1;
      end
      PROBE: begin
        if (idx == probe_idx_t'(NPROBE - 1)) begin
          state_nxt = DRAIN;
        end else begin
          idx_nxt = idx + 4'd1;
          issue_c = 1'b1;
        end
      end
      DRAIN:   state_nxt = COMMIT;
      COMMIT:  state_nxt = SNAP;
      default: state_nxt = SNAP;
    endcase
  end

  assign src_x = (state == SNAP) ? xpos : px;
  assign src_y = (state == SNAP) ? ypos : py;

  maze_probe_gen u_probe_gen (
    .px  (src_x),
    .py  (src_y),
    .idx (idx_nxt),
    .row (g_row),
    .col (g_col),
    .oob (g_oob),
    .tun (g_tun),
    .dir (g_dir)
  );

`ifdef MAZE_TUNNEL_WRAP_EN
  assign tun_ok_c = tag2.tun;
`else
  assign tun_ok_c = 1'b0;
`endif

  // Out-of-bounds probes are walls unless they fall in the open tunnel band
  always_comb begin
    blocked_c = tag2.oob ? !tun_ok_c : wall_bit;
    acc_cap_c = acc;
    if (tag2.valid && blocked_c) acc_cap_c[tag2.dir] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px         <= '0;
      py         <= '0;
      wall_re    <= 1'b0;
      wall_row   <= '0;
      wall_col   <= '0;
      tag1       <= '0;
      tag2       <= '0;
      acc        <= '1;
      leg_r      <= 1'b0;
      leg_l      <= 1'b0;
      leg_u      <= 1'b0;
      leg_d      <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      if (state == SNAP) begin
        px <= xpos;
        py <= ypos;
      end
      wall_re    <= issue_c && !g_oob;
      wall_row   <= (issue_c && !g_oob) ? g_row : '0;
      wall_col   <= (issue_c && !g_oob) ? g_col : '0;
      tag1       <= '{valid: issue_c, dir: g_dir, oob: g_oob, tun: g_tun};
      tag2       <= tag1;
      acc        <= (state == SNAP) ? 4'hF : acc_cap_c;
      sweep_done <= (state == DRAIN);
      if (state == DRAIN) begin
        leg_r <= acc_cap_c[DIR_R];
        leg_l <= acc_cap_c[DIR_L];
        leg_u <= acc_cap_c[DIR_U];
        leg_d <= acc_cap_c[DIR_D];
      end
    end
  end

endmodule
